// File: rtl/mvm3_pkg.sv
// Shared widths, FSM state type and operand index helpers for the 3x3 matrix-vector multiplier.
package mvm3_pkg;

  localparam int DIN_W  = 8;
  localparam int DOUT_W = 16;
  localparam int N      = 3;
  localparam int NUM_IN = N * N + N;
  localparam int IDX_W  = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Matrix elements occupy slots 0..8 row-major; the vector follows at slots 9..11.
  function automatic logic [IDX_W-1:0] a_index(input logic [1:0] row, input logic [1:0] col);
    return IDX_W'(row) * IDX_W'(N) + IDX_W'(col);
  endfunction

  function automatic logic [IDX_W-1:0] x_index(input logic [1:0] col);
    return IDX_W'(N * N) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/mvm3_mac.sv
// Signed 8x8 multiply-accumulate with 16-bit wrapping sum and sticky per-row overflow flag.
// Overflow detection is built only when MVM3_OVERFLOW_DETECT_EN is defined; otherwise ovf is tied low.
module mvm3_mac
  import mvm3_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DIN_W-1:0]  a,
  input  logic signed [DIN_W-1:0]  b,
  output logic signed [DOUT_W-1:0] acc,
  output logic                     ovf
);

  logic signed [DOUT_W-1:0] a_ext;
  logic signed [DOUT_W-1:0] b_ext;
  logic signed [DOUT_W-1:0] prod;
  logic signed [DOUT_W-1:0] sum;

  // 8x8 signed product always fits in 16 bits, so the low half of a 16x16 multiply is exact.
  assign a_ext = DOUT_W'(a);
  assign b_ext = DOUT_W'(b);
  assign prod  = a_ext * b_ext;
  assign sum   = acc + prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

`ifdef MVM3_OVERFLOW_DETECT_EN
  logic add_ovf;
  logic ovf_q;

  assign add_ovf = (acc[DOUT_W-1] == prod[DOUT_W-1]) && (sum[DOUT_W-1] != acc[DOUT_W-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (clr) begin
      ovf_q <= 1'b0;
    end else if (en && add_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mvm3_part1.sv
// 3x3 signed matrix times 3-vector: loads A row-major then x, streams y0..y2 with valid/ready.
// Optional overflow detection is enabled by defining MVM3_OVERFLOW_DETECT_EN.
//
// state | meaning
// LOAD  | accept 12 samples into storage, s_ready high
// MAC   | three multiply-accumulate cycles for the current row
// OUT   | present y[row] until the downstream accepts it
module mvm3_part1
  import mvm3_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DIN_W-1:0]  data_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DOUT_W-1:0] data_out,
  output logic              overflow
);

  state_e                   state;
  logic [IDX_W-1:0]         idx;
  logic [1:0]               row;
  logic [1:0]               k;
  logic [DIN_W-1:0]         mem [NUM_IN];

  logic                     in_hs;
  logic                     out_hs;
  logic                     last_in;
  logic                     mac_clr;
  logic                     mac_en;
  logic signed [DIN_W-1:0]  op_a;
  logic signed [DIN_W-1:0]  op_b;
  logic signed [DOUT_W-1:0] acc;
  logic                     ovf;

  assign s_ready = (state == LOAD);
  assign m_valid = (state == OUT);
  assign in_hs   = s_ready && s_valid;
  assign out_hs  = m_valid && m_ready;
  assign last_in = (idx == IDX_W'(NUM_IN - 1));

  // Clear the accumulator on the edge that enters MAC so the first product lands on a clean sum.
  assign mac_clr = (in_hs && last_in) || (out_hs && (row != 2'd2));
  assign mac_en  = (state == MAC);

  assign op_a = mem[a_index(row, k)];
  assign op_b = mem[x_index(k)];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN; i++) mem[i] <= '0;
    end else if (in_hs) begin
      mem[idx] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      idx   <= '0;
      row   <= '0;
      k     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            if (last_in) begin
              idx   <= '0;
              row   <= '0;
              k     <= '0;
              state <= MAC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        MAC: begin
          if (k == 2'd2) begin
            k     <= '0;
            state <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_hs) begin
            if (row == 2'd2) begin
              row   <= '0;
              idx   <= '0;
              state <= LOAD;
            end else begin
              row   <= row + 1'b1;
              state <= MAC;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  mvm3_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (op_a),
    .b     (op_b),
    .acc   (acc),
    .ovf   (ovf)
  );

  assign data_out = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_mvm3_part1.sv
// Scoreboard bench for mvm3_part1: directed jobs push expected y/overflow, a monitor pops on each output handshake.
module tb_mvm3_part1;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  data_in;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] data_out;
  logic        overflow;

`ifdef MVM3_OVERFLOW_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    int y;
    bit o;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit         rand_in = 0;
  logic [7:0] vec [12];

  mvm3_part1 dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input int y, input bit o);
    exp_t e;
    e.y = y;
    e.o = o & OVF_EN;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: the handshake completes at the next rising edge, values are stable now.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("y", int'($signed(data_out)), e.y);
        check("overflow", int'(overflow), int'(e.o));
      end
    end
  end

  // Latency checker: m_valid must rise after the 3rd edge following an accepting handshake.
  int in_cnt = 0, out_cnt = 0, edges = 0;
  bit armed = 0, prev_mv = 0, hs_in = 0, hs_out = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_cnt = 0; out_cnt = 0; armed = 0; prev_mv = 0; hs_in = 0; hs_out = 0;
    end else begin
      if (m_valid && !prev_mv && armed) begin
        check("latency", edges, 3);
        armed = 0;
      end
      prev_mv = m_valid;
      hs_in   = s_valid && s_ready;
      hs_out  = m_valid && m_ready;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      edges++;
      if (hs_in) begin
        in_cnt++;
        if (in_cnt == 12) begin
          in_cnt = 0; edges = 0; armed = 1;
        end
      end
      if (hs_out) begin
        out_cnt++;
        if (out_cnt % 3 != 0) begin
          edges = 0; armed = 1;
        end
      end
      hs_in = 0;
      hs_out = 0;
    end
  end

  task automatic send_word(input logic [7:0] d);
    int guard = 0;
    if (rand_in) begin
      while ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    data_in = d;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      guard++;
      if (guard > 500) begin
        check("s_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    data_in = 'x;
  endtask

  task automatic send_job();
    for (int i = 0; i < 12; i++) send_word(vec[i]);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_s_ready"}, int'(s_ready), 1);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_data_out"}, int'(data_out), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic load_basic();
    vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd2, 8'd3};
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; data_in = 'x; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic job with random handshakes.
    rand_in = 1; rdy_mode = 1;
    load_basic();
    push_exp(14, 0); push_exp(32, 0); push_exp(50, 0);
    send_job();
    drain();

    // All 127: 3*16129 = 48387 wraps to -17149.
    rand_in = 0; rdy_mode = 0;
    vec = '{8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h7f};
    push_exp(-17149, 1); push_exp(-17149, 1); push_exp(-17149, 1);
    send_job();
    drain();

    // A all -128, x all 1.
    vec = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01};
    push_exp(-384, 0); push_exp(-384, 0); push_exp(-384, 0);
    send_job();
    drain();

    // Row0 -128 with x -128: 16384+16384 overflows to -32768, then -16384; rows 1,2 no overflow.
    vec = '{8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80};
    push_exp(-16384, 1); push_exp(-384, 0); push_exp(0, 0);
    send_job();
    drain();

    // Output stall with s_valid pushed during OUT.
    rdy_mode = 2;
    load_basic();
    push_exp(14, 0); push_exp(32, 0); push_exp(50, 0);
    send_job();
    begin
      int guard = 0;
      while (!m_valid && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check("stall_reach_out", int'(m_valid), 1);
    end
    s_valid = 1'b1; data_in = 8'h55;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_data_out", int'($signed(data_out)), 14);
      check("stall_m_valid", int'(m_valid), 1);
      check("stall_s_ready", int'(s_ready), 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; data_in = 'x;
    rdy_mode = 0;
    drain();

    // Reset after 7 inputs, then a full job from a00.
    for (int i = 0; i < 7; i++) send_word(8'h55);
    reset = 1'b1;
    check_reset_state("midjob_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    load_basic();
    push_exp(14, 0); push_exp(32, 0); push_exp(50, 0);
    send_job();
    drain();

    // Back-to-back jobs, continuous valid/ready.
    load_basic();
    push_exp(14, 0); push_exp(32, 0); push_exp(50, 0);
    push_exp(-384, 0); push_exp(-384, 0); push_exp(-384, 0);
    send_job();
    vec = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01};
    send_job();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mvm3_part1.md
MVM3_PART1 -- requirements
Module: mvm3_part1

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 s_valid  input  1  upstream asserts: data_in valid this cycle.
REQ-004 s_ready  output  1  block can accept data_in this cycle.
REQ-005 data_in  input  8  signed two's-complement input sample; ignored (may be X) when s_valid=0.
REQ-006 m_valid  output  1  data_out/overflow hold a valid result.
REQ-007 m_ready  input  1  downstream accepts the result this cycle.
REQ-008 data_out  output  16  signed result element y[r].
REQ-009 overflow  output  1  signed 16-bit overflow occurred while computing current data_out; meaningful only while m_valid=1.

Function
REQ-010 Block SHALL compute y = A*x, A a 3x3 signed 8-bit matrix, x a 3-element signed 8-bit vector, y three signed 16-bit values.
REQ-011 Input transfer SHALL occur on a rising edge with s_valid=1 and s_ready=1; 12 transfers per job: A row-major (a00,a01,a02,a10,...,a22), then x0,x1,x2.
REQ-012 Output transfer SHALL occur on a rising edge with m_valid=1 and m_ready=1; outputs in order y0,y1,y2.
REQ-013 FSM states: LOAD, MAC, OUT; s_ready=1 only in LOAD; m_valid=1 only in OUT.
REQ-014 LOAD: store each transferred sample at index 0..11; on 12th transfer go to MAC with row r=0, accumulator and overflow flag cleared.
REQ-015 MAC: one product per cycle, acc <= acc + a[r][k]*x[k] for k=0,1,2; after third MAC cycle go to OUT.
REQ-016 Latency: m_valid SHALL rise immediately after the 3rd rising edge following the accepting (12th input or previous output) handshake edge.
REQ-017 OUT: data_out and overflow SHALL remain stable while m_valid=1 and m_ready=0.
REQ-018 On output handshake: if r<2, r<=r+1, clear acc/flag, go to MAC; if r=2, go to LOAD with input index 0.
REQ-019 Products SHALL be full signed 8x8 (16-bit, never overflow); sums SHALL wrap modulo 2^16.
REQ-020 Overflow flag SHALL be sticky per row: set when an addition's operands share a sign and the 16-bit sum's sign differs.
REQ-021 s_valid outside LOAD and m_ready outside OUT SHALL have no effect; X on data_in with s_valid=0 SHALL not propagate.

Reset
REQ-022 While reset=1: state LOAD, input index 0, r=0, acc 0, s_ready=1, m_valid=0, data_out=0, overflow=0.
REQ-023 Reset asserted mid-job SHALL discard all partial inputs and results; next job starts at a00.

Configuration
REQ-024 Macro MVM3_OVERFLOW_DETECT_EN defined: overflow per REQ-020.
REQ-025 Macro MVM3_OVERFLOW_DETECT_EN undefined: overflow tied to 0, detection logic absent; data_out unchanged.

Structure
REQ-026 Package mvm3_pkg SHALL hold DIN_W=8, DOUT_W=16, N=3, state enum type (LOAD/MAC/OUT).
REQ-027 One sub-module mvm3_mac SHALL implement signed multiply, accumulate and overflow detect; control FSM and 12-entry storage in mvm3_part1.

Verification
REQ-028 A=[1,2,3;4,5,6;7,8,9], x=[1,2,3], random s_valid/m_ready -> y=14,32,50, overflow=0 each.
REQ-029 A all 127, x all 127 -> y0..y2 = 48387 mod 2^16 = -17149, overflow=1 each.
REQ-030 A all -128, x all 1 -> y=-384 each, overflow=0; A row0=-128, x=-128 -> y0=-16384 wraps, overflow=1.
REQ-031 m_ready held 0 for 20 cycles in OUT -> data_out/m_valid stable, s_ready=0, no extra input taken.
REQ-032 Reset pulsed after 7 inputs, then full 12-input job of REQ-028 -> y=14,32,50.
REQ-033 Two back-to-back jobs with continuous valid/ready -> six correct outputs; m_valid 3 edges after each accepting handshake.
